// File: rtl/hazard_unit_mc_pkg.sv
// Shared types and helpers for the multi-cycle-aware hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int unsigned REG_ZERO = 0;

  function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
    fwd_sel_t sel;
    if (hit_m) begin
      sel = FWD_MEM;
    end else if (hit_w) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-hazard-unit signal bundle; the datapath is master, the hazard unit slave.
interface hazard_unit_mc_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] rs1_d, rs2_d, rd_d;
  logic                      reg_write_d, mc_op_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_e, rs2_e, rd_e;
  logic                      load_e, mc_start_e, pc_src_e;
  logic [REG_ADDR_WIDTH-1:0] rd_m, rd_w;
  logic                      reg_write_m, reg_write_w;
  logic [1:0]                forward_a_e, forward_b_e;
  logic                      stall_f, stall_d, flush_d, flush_e;
  logic                      mc_busy, mc_done;
  logic [REG_ADDR_WIDTH-1:0] mc_rd;

  modport master (
    output rs1_d, rs2_d, rd_d, reg_write_d, mc_op_d,
    output rs1_e, rs2_e, rd_e, load_e, mc_start_e, pc_src_e,
    output rd_m, reg_write_m, rd_w, reg_write_w,
    input  forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
    input  mc_busy, mc_done, mc_rd
  );

  modport slave (
    input  rs1_d, rs2_d, rd_d, reg_write_d, mc_op_d,
    input  rs1_e, rs2_e, rd_e, load_e, mc_start_e, pc_src_e,
    input  rd_m, reg_write_m, rd_w, reg_write_w,
    output forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
    output mc_busy, mc_done, mc_rd
  );
endinterface

// File: rtl/hazard_unit_mc_sb.sv
// Single-entry scoreboard and countdown timer for one fixed-latency multi-cycle unit.
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mc_start_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d_i,
  input  logic                      reg_write_d_i,
  input  logic                      mc_op_d_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [REG_ADDR_WIDTH-1:0] pend_rd_o,
  output logic                      sb_stall_o
);
  localparam int CNT_WIDTH = $clog2(MC_LATENCY) + 1;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO = REG_ADDR_WIDTH'(REG_ZERO);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MC_LATENCY - 1);

  logic                      busy_q, busy_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_WIDTH-1:0] pend_rd_q, pend_rd_d;
  logic                      done_s, live_s, struct_s, hit_pend_s, hit_new_s;

  function automatic logic dep_hit(
    input logic [REG_ADDR_WIDTH-1:0] tgt,
    input logic [REG_ADDR_WIDTH-1:0] rs1,
    input logic [REG_ADDR_WIDTH-1:0] rs2,
    input logic [REG_ADDR_WIDTH-1:0] rd,
    input logic                      wr,
    input logic                      structural
  );
    return (tgt != ZERO) && ((tgt == rs1) || (tgt == rs2) || (wr && (tgt == rd)) || structural);
  endfunction

  // Next-state: a start in the completion cycle reloads; a start while still counting is ignored.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    if (mc_start_i && !live_s) begin
      busy_d    = 1'b1;
      cnt_d     = CNT_LOAD;
      pend_rd_d = rd_e_i;
    end else if (done_s) begin
      busy_d = 1'b0;
    end else if (busy_q && !mc_start_i) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      pend_rd_q <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
    end
  end

  // Write-through regfile releases dependants in the done cycle itself.
  always_comb begin
    done_s     = busy_q && (cnt_q == '0);
    live_s     = busy_q && !done_s;
    struct_s   = mc_op_d_i && (live_s || mc_start_i);
    hit_pend_s = live_s && dep_hit(pend_rd_q, rs1_d_i, rs2_d_i, rd_d_i, reg_write_d_i, struct_s);
    hit_new_s  = mc_start_i && dep_hit(rd_e_i, rs1_d_i, rs2_d_i, rd_d_i, reg_write_d_i, struct_s);
  end

  assign busy_o     = busy_q;
  assign done_o     = done_s;
  assign pend_rd_o  = pend_rd_q;
  assign sb_stall_o = hit_pend_s || hit_new_s;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit: EX forwarding, load-use and scoreboard stalls, branch flush.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LATENCY     = 4
) (
  input logic             clk,
  input logic             rst_n,
  hazard_unit_mc_if.slave hz
);
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO = REG_ADDR_WIDTH'(REG_ZERO);

  fwd_sel_t                  fwd_a_s, fwd_b_s;
  logic                      lw_stall_s, sb_stall_s, stall_s;
  logic                      busy_s, done_s;
  logic [REG_ADDR_WIDTH-1:0] pend_rd_s;

  mc_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .MC_LATENCY     (MC_LATENCY)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .mc_start_i    (hz.mc_start_e),
    .rd_e_i        (hz.rd_e),
    .rs1_d_i       (hz.rs1_d),
    .rs2_d_i       (hz.rs2_d),
    .rd_d_i        (hz.rd_d),
    .reg_write_d_i (hz.reg_write_d),
    .mc_op_d_i     (hz.mc_op_d),
    .busy_o        (busy_s),
    .done_o        (done_s),
    .pend_rd_o     (pend_rd_s),
    .sb_stall_o    (sb_stall_s)
  );

  // Operand forwarding (M over W, never x0) and load-use detection.
  always_comb begin
    fwd_a_s = fwd_pick(hz.reg_write_m && (hz.rd_m == hz.rs1_e) && (hz.rs1_e != ZERO),
                       hz.reg_write_w && (hz.rd_w == hz.rs1_e) && (hz.rs1_e != ZERO));
    fwd_b_s = fwd_pick(hz.reg_write_m && (hz.rd_m == hz.rs2_e) && (hz.rs2_e != ZERO),
                       hz.reg_write_w && (hz.rd_w == hz.rs2_e) && (hz.rs2_e != ZERO));
    lw_stall_s = hz.load_e && (hz.rd_e != ZERO) &&
                 ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
    stall_s = lw_stall_s || sb_stall_s;
  end

  // Output combine; a taken branch overrides stalls, and reset forces a flushed pipeline.
  always_comb begin
    hz.forward_a_e = FWD_RF;
    hz.forward_b_e = FWD_RF;
    hz.stall_f     = 1'b0;
    hz.stall_d     = 1'b0;
    hz.flush_d     = 1'b1;
    hz.flush_e     = 1'b1;
    hz.mc_busy     = 1'b0;
    hz.mc_done     = 1'b0;
    hz.mc_rd       = '0;
    if (rst_n) begin
      hz.forward_a_e = fwd_a_s;
      hz.forward_b_e = fwd_b_s;
      hz.stall_f     = stall_s && !hz.pc_src_e;
      hz.stall_d     = stall_s && !hz.pc_src_e;
      hz.flush_d     = hz.pc_src_e;
      hz.flush_e     = stall_s || hz.pc_src_e;
      hz.mc_busy     = busy_s;
      hz.mc_done     = done_s;
      hz.mc_rd       = pend_rd_s;
    end else begin
      hz.mc_rd = '0;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc (MC_LATENCY=4).
module tb_hazard_unit_mc;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  hazard_unit_mc_if #(.REG_ADDR_WIDTH(5)) hif ();

  hazard_unit_mc #(.REG_ADDR_WIDTH(5), .MC_LATENCY(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: no start while an op is still counting down.
  always @(posedge clk) begin
    if (rst_n && hif.mc_start_e && hif.mc_busy && !hif.mc_done) begin
      tests_failed++;
      $display("FAIL protocol_start_while_busy: mc_start_e=1 busy=%b done=%b", hif.mc_busy, hif.mc_done);
    end
  end

  task automatic idle();
    hif.rs1_d = 5'd0; hif.rs2_d = 5'd0; hif.rd_d = 5'd0; hif.reg_write_d = 1'b0; hif.mc_op_d = 1'b0;
    hif.rs1_e = 5'd0; hif.rs2_e = 5'd0; hif.rd_e = 5'd0; hif.load_e = 1'b0; hif.mc_start_e = 1'b0;
    hif.pc_src_e = 1'b0; hif.rd_m = 5'd0; hif.reg_write_m = 1'b0; hif.rd_w = 5'd0; hif.reg_write_w = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    hif.reg_write_m = 1'b1; hif.rd_m = 5'd5; hif.rs1_e = 5'd5;
    hif.load_e = 1'b1; hif.rd_e = 5'd7; hif.rs1_d = 5'd7;
    #1;
    chk("rst_fwd_a", {6'd0, hif.forward_a_e}, 8'h00);
    chk("rst_stall_d", {7'd0, hif.stall_d}, 8'h00);
    chk("rst_flush", {6'd0, hif.flush_d, hif.flush_e}, 8'h03);
    chk("rst_done_busy", {6'd0, hif.mc_done, hif.mc_busy}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    chk("post_rst_flags", {2'd0, hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e, hif.mc_busy, hif.mc_done}, 8'h00);
    chk("post_rst_mc_rd", {3'd0, hif.mc_rd}, 8'h00);
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    idle();
    hif.rd_m = 5'd5; hif.reg_write_m = 1'b1; hif.rd_w = 5'd5; hif.reg_write_w = 1'b1;
    hif.rs1_e = 5'd5; hif.rs2_e = 5'd5;
    #1;
    chk("fwd_a_mem_prio", {6'd0, hif.forward_a_e}, 8'h02);
    chk("fwd_b_mem_prio", {6'd0, hif.forward_b_e}, 8'h02);
    hif.reg_write_m = 1'b0;
    #1;
    chk("fwd_a_wb", {6'd0, hif.forward_a_e}, 8'h01);
    hif.reg_write_m = 1'b1; hif.rd_w = 5'd6; hif.rs2_e = 5'd6;
    #1;
    chk("fwd_b_wb_only", {6'd0, hif.forward_b_e}, 8'h01);
    hif.rs2_e = 5'd11;
    #1;
    chk("fwd_b_nomatch", {6'd0, hif.forward_b_e}, 8'h00);
    hif.rd_m = 5'd0; hif.rd_w = 5'd0; hif.rs1_e = 5'd0;
    #1;
    chk("fwd_a_x0", {6'd0, hif.forward_a_e}, 8'h00);
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    hif.load_e = 1'b1; hif.rd_e = 5'd7; hif.rs2_d = 5'd7;
    #1;
    chk("lu_sf_sd_fd_fe", {4'd0, hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e}, 8'h0D);
    @(negedge clk);
    hif.load_e = 1'b0; hif.rd_e = 5'd0;
    #1;
    chk("lu_one_cycle", {4'd0, hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e}, 8'h00);
    hif.load_e = 1'b1; hif.rd_e = 5'd0; hif.rs2_d = 5'd0;
    #1;
    chk("lu_x0_nostall", {7'd0, hif.stall_d}, 8'h00);
  endtask

  task automatic test_branch_override();
    @(negedge clk);
    idle();
    hif.load_e = 1'b1; hif.rd_e = 5'd7; hif.rs2_d = 5'd7; hif.pc_src_e = 1'b1;
    #1;
    chk("br_sf_sd_fd_fe", {4'd0, hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e}, 8'h03);
  endtask

  task automatic test_mc_raw();
    @(negedge clk);
    idle();
    hif.mc_start_e = 1'b1; hif.rd_e = 5'd9; hif.rs1_d = 5'd9;
    #1;
    chk("mc_raw_t_stall", {5'd0, hif.stall_d, hif.flush_d, hif.flush_e}, 8'h05);
    hif.rs1_d = 5'd3;
    #1;
    chk("mc_x3_t", {7'd0, hif.stall_d}, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      hif.mc_start_e = 1'b0; hif.rd_e = 5'd0; hif.rs1_d = 5'd9;
      #1;
      chk($sformatf("mc_raw_stall_t%0d", k), {7'd0, hif.stall_d}, (k < 4) ? 8'h01 : 8'h00);
      chk($sformatf("mc_done_busy_t%0d", k), {6'd0, hif.mc_done, hif.mc_busy}, (k < 4) ? 8'h01 : 8'h03);
      chk($sformatf("mc_rd_t%0d", k), {3'd0, hif.mc_rd}, 8'h09);
      hif.rs1_d = 5'd3;
      #1;
      chk($sformatf("mc_x3_t%0d", k), {7'd0, hif.stall_d}, 8'h00);
    end
    @(negedge clk);
    idle();
    #1;
    chk("mc_idle_after", {6'd0, hif.mc_done, hif.mc_busy}, 8'h00);
  endtask

  task automatic test_structural_waw();
    @(negedge clk);
    idle();
    hif.mc_start_e = 1'b1; hif.rd_e = 5'd9; hif.mc_op_d = 1'b1;
    #1;
    chk("st_stall_t0", {7'd0, hif.stall_d}, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      hif.mc_start_e = 1'b0; hif.rd_e = 5'd0;
      #1;
      chk($sformatf("st_stall_t%0d", k), {7'd0, hif.stall_d}, (k < 4) ? 8'h01 : 8'h00);
    end
    chk("st_done_t4", {7'd0, hif.mc_done}, 8'h01);
    // t+5: the held mc op enters E; the next D instruction writes x9.
    for (int k = 5; k <= 9; k++) begin
      @(negedge clk);
      hif.mc_start_e = (k == 5); hif.rd_e = (k == 5) ? 5'd9 : 5'd0;
      hif.mc_op_d = 1'b0; hif.reg_write_d = 1'b1; hif.rd_d = 5'd9;
      #1;
      chk($sformatf("waw_stall_t%0d", k), {7'd0, hif.stall_d}, (k < 9) ? 8'h01 : 8'h00);
      chk($sformatf("st2_done_t%0d", k), {7'd0, hif.mc_done}, (k == 9) ? 8'h01 : 8'h00);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    idle();
    hif.mc_start_e = 1'b1; hif.rd_e = 5'd9;
    @(negedge clk);
    idle();
    hif.rs1_d = 5'd9;
    #1;
    chk("rmo_busy_t1", {7'd0, hif.mc_busy}, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    hif.reg_write_m = 1'b1; hif.rd_m = 5'd5; hif.rs1_e = 5'd5;
    #1;
    chk("rmo_rst_fwd", {6'd0, hif.forward_a_e}, 8'h00);
    chk("rmo_rst_flags", {2'd0, hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e, hif.mc_busy, hif.mc_done}, 8'h0C);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    hif.rs1_d = 5'd9;
    #1;
    chk("rmo_busy_t3", {6'd0, hif.mc_busy, hif.stall_d}, 8'h00);
    @(negedge clk);
    #1;
    chk("rmo_nodone_t4", {7'd0, hif.mc_done}, 8'h00);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_override();
    test_mc_raw();
    test_structural_waw();
    test_reset_mid_op();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised hazard unit for the 5-stage pipelined RV32I core, extending the base forwarding and stall logic.
- Combinational part: EX-stage operand forwarding select, load-use stall and branch flush generation.
- Sequential part: a single-entry scoreboard and countdown timer for one fixed-latency multi-cycle unit (mul/div).
- Scoreboard/timer produce RAW, WAW and structural stalls plus a writeback-complete pulse.
- Sits beside the datapath and drives stall/flush enables of the F/D/E pipeline registers.

Parameters:
REG_ADDR_WIDTH, 5, register index width
MC_LATENCY, 4, cycles from multi-cycle op in E to its result write (>=1)
CNT_WIDTH, $clog2(MC_LATENCY)+1, timer width (derived, localparam)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
rs1_d, rs2_d  in  REG_ADDR_WIDTH  decode sources
rd_d  in  REG_ADDR_WIDTH  decode destination
reg_write_d  in  1  decode instruction writes rd
mc_op_d  in  1  decode instruction is multi-cycle
rs1_e, rs2_e, rd_e  in  REG_ADDR_WIDTH  execute regs
load_e  in  1  E instruction is a load
mc_start_e  in  1  multi-cycle op valid in E
pc_src_e  in  1  branch/jump taken in E
rd_m  in  REG_ADDR_WIDTH  memory-stage destination
reg_write_m  in  1  M writes rd
rd_w  in  REG_ADDR_WIDTH  writeback destination
reg_write_w  in  1  W writes rd
forward_a_e, forward_b_e  out  2  operand select: 00 regfile, 01 W, 10 M
stall_f, stall_d  out  1  hold PC / IF-ID
flush_d, flush_e  out  1  bubble IF-ID / ID-EX
mc_busy  out  1  multi-cycle op outstanding
mc_done  out  1  one-cycle pulse: multi-cycle result written this cycle
mc_rd  out  REG_ADDR_WIDTH  destination of outstanding op

Behaviour:
- Forwarding (per operand):
  - 10 if reg_write_m & rd_m==rs_e & rs_e!=0.
  - Else 01 if reg_write_w & rd_w==rs_e & rs_e!=0.
  - Else 00. M has priority over W; x0 is never forwarded.
- lw_stall = load_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- Scoreboard state: busy, cnt[CNT_WIDTH], pend_rd.
  - Reset: busy=0, cnt=0, pend_rd=0.
  - mc_done = busy & cnt==0 (combinational from state).
  - Register update:
    - On mc_start_e: busy<=1, cnt<=MC_LATENCY-1, pend_rd<=rd_e.
    - Else if mc_done: busy<=0.
    - Else if busy: cnt<=cnt-1.
  - mc_start_e in the mc_done cycle is legal: reload; the old pulse still appears.
  - mc_start_e while busy & ~mc_done is a protocol violation: ignored, state unchanged, bench asserts it never occurs.
- Example, MC_LATENCY=4: start at cycle t, cnt 3,2,1,0 at t+1..t+4, mc_done at t+4. MC_LATENCY=1 gives mc_done at t+1.
- pend_live = (busy & ~mc_done) matches on pend_rd, or mc_start_e matches on rd_e. The regfile is write-through, so release happens in the mc_done cycle.
- sb_stall: pend_live & target!=0 & any of:
  - RAW: target==rs1_d or target==rs2_d.
  - WAW: reg_write_d & target==rd_d.
  - Structural: mc_op_d & (busy & ~mc_done | mc_start_e).
- Stall and flush outputs:
  - stall_f = stall_d = (lw_stall | sb_stall) & ~pc_src_e.
  - flush_d = pc_src_e.
  - flush_e = lw_stall | sb_stall | pc_src_e.
  - A taken branch overrides stalls: the wrong-path D instruction is flushed.
- mc_busy = busy; mc_rd = pend_rd.
- While rst_n=0: forwards 00, stall_f=stall_d=0, flush_d=flush_e=1, mc_done=0.
- Reset mid-operation clears busy with no mc_done pulse.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_ZERO constant.
- Sub-module mc_scoreboard: busy/cnt/pend_rd registers, mc_done, pend_live match logic. The top level keeps forwarding, lw_stall and the stall/flush combine.

Test Plan:
- rd_m=rd_w=5, both writing, rs1_e=5 -> forward_a_e=10. Clear reg_write_m -> 01. rs1_e=0 with rd_m=0 writing -> 00.
- load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1, flush_d=0, for exactly one cycle.
- Same load-use plus pc_src_e=1 -> stall_f=stall_d=0, flush_d=flush_e=1.
- MC_LATENCY=4, mc_start_e with rd_e=9 at t; D reads x9 from t through t+3:
  - Stall asserted t..t+3, mc_done at t+4, stall released at t+4.
  - A D instruction reading x3 is never stalled.
- Structural case: mc_op_d held while busy -> stalled until the mc_done cycle. Second mc_start_e at t+5 -> next mc_done at t+9. WAW on rd_d=9 stalls the same way.
- mc_start_e at t, rst_n=0 at t+2 for one cycle -> busy=0 at t+3, no mc_done at t+4, outputs at reset values during the reset cycle.
